ethernet_udp_receive: RTL

MII receive path, the counterpart of ethernet_udp_transmit. It samples the PHY receive nibble stream on the system clock and strips preamble/SFD, Ethernet, IPv4 and UDP headers. It filters frames against the local MAC/IP/port and checks the FCS. Each accepted datagram delivers a fixed-width payload plus the sender's addressing, so the top level can answer or log packets.

---
 rtl/ethernet_udp_receive_if.sv | 27 ++
 rtl/ethernet_udp_receive.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ethernet_udp_receive_if.sv
// PHY-side MII receive signals, local address filters and the delivered datagram.
interface ethernet_udp_receive_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                    rx_clk;
    logic                    rx_dv;
    logic [3:0]              rx_d;
    logic [47:0]             local_mac;
    logic [31:0]             local_ip;
    logic [15:0]             local_port;
    logic [DATA_WIDTH*8-1:0] data;
    logic [47:0]             src_mac;
    logic [31:0]             src_ip;
    logic [15:0]             src_port;
    logic                    valid;
    logic                    error;

    modport master (
        output rx_clk, rx_dv, rx_d, local_mac, local_ip, local_port,
        input  data, src_mac, src_ip, src_port, valid, error
    );

    modport slave (
        input  rx_clk, rx_dv, rx_d, local_mac, local_ip, local_port,
        output data, src_mac, src_ip, src_port, valid, error
    );
endinterface

// File: rtl/ethernet_udp_receive.sv
// MII receive path: synchronises the PHY nibble stream, strips Ethernet/IPv4/UDP
// headers, filters on local MAC/IP/port and delivers a fixed-size payload on good FCS.
module ethernet_udp_receive #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MIN_FRAME  = 64
) (
    input logic                  clk,
    input logic                  reset,
    ethernet_udp_receive_if.slave bus
);
    localparam int unsigned   PW          = DATA_WIDTH * 8;
    localparam int unsigned   CW          = 11;
    localparam logic [CW-1:0] HDR_LAST    = CW'(41);
    localparam logic [CW-1:0] PAY_LAST    = CW'(41 + DATA_WIDTH);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [15:0]   UDP_LEN     = 16'(8 + DATA_WIDTH);
    localparam logic [31:0]   CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] HEADER   = 3'd2;
    localparam logic [2:0] PAYLOAD  = 3'd3;
    localparam logic [2:0] TRAIL    = 3'd4;
    localparam logic [2:0] CHECK    = 3'd5;
    localparam logic [2:0] DROP     = 3'd6;

    logic [2:0]    state, state_nx;
    logic [2:0]    rx_clk_s;
    logic [1:0]    rx_dv_s;
    logic [3:0]    rx_d_s0, rx_d_s1;
    logic          armed, nib_hi;
    logic [3:0]    nib_lo;
    logic [CW-1:0] byte_cnt;
    logic [31:0]   crc;
    logic [39:0]   field_sh;
    logic [PW-1:0] pay_sh;
    logic [47:0]   stage_src_mac;
    logic [31:0]   stage_src_ip;
    logic [15:0]   stage_src_port;

    logic          dv_c, nib_stb_c, in_frame_c, byte_stb_c, hdr_ok_c;
    logic [3:0]    nib_c;
    logic [7:0]    rx_byte_c;
    logic [47:0]   hdr_cur_c;

    assign dv_c       = rx_dv_s[1];
    assign nib_c      = rx_d_s1;
    assign nib_stb_c  = rx_clk_s[1] & ~rx_clk_s[2] & dv_c;
    assign in_frame_c = (state == HEADER) || (state == PAYLOAD) || (state == TRAIL);
    assign byte_stb_c = nib_stb_c & nib_hi & in_frame_c;
    assign rx_byte_c  = {nib_c, nib_lo};
    assign hdr_cur_c  = {field_sh, rx_byte_c};

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    // Field filter, evaluated on the last byte of each checked header field.
    always_comb begin
        hdr_ok_c = 1'b1;
        case (byte_cnt)
            11'd5:  hdr_ok_c = (hdr_cur_c == bus.local_mac) || (hdr_cur_c == 48'hFFFF_FFFF_FFFF);
            11'd13: hdr_ok_c = (hdr_cur_c[15:0] == 16'h0800);
            11'd14: hdr_ok_c = (rx_byte_c == 8'h45);
            11'd23: hdr_ok_c = (rx_byte_c == 8'd17);
            11'd33: hdr_ok_c = (hdr_cur_c[31:0] == bus.local_ip);
            11'd37: hdr_ok_c = (hdr_cur_c[15:0] == bus.local_port);
            11'd39: hdr_ok_c = (hdr_cur_c[15:0] == UDP_LEN);
            default: hdr_ok_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (nib_stb_c && armed) state_nx = PREAMBLE;
            PREAMBLE: begin
                if (!dv_c)                 state_nx = IDLE;
                else if (nib_stb_c) begin
                    if (nib_c == 4'hD)      state_nx = HEADER;
                    else if (nib_c != 4'h5) state_nx = DROP;
                end
            end
            HEADER: begin
                if (!dv_c)                      state_nx = IDLE;
                else if (byte_stb_c) begin
                    if (!hdr_ok_c)              state_nx = DROP;
                    else if (byte_cnt == HDR_LAST) state_nx = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!dv_c)                                     state_nx = IDLE;
                else if (byte_stb_c && byte_cnt == PAY_LAST)   state_nx = TRAIL;
            end
            TRAIL:    if (!dv_c) state_nx = CHECK;
            CHECK:    state_nx = IDLE;
            DROP:     if (!dv_c) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_clk_s       <= '0;
            rx_dv_s        <= '0;
            rx_d_s0        <= '0;
            rx_d_s1        <= '0;
            armed          <= 1'b0;
            nib_hi         <= 1'b0;
            nib_lo         <= '0;
            byte_cnt       <= '0;
            crc            <= 32'hFFFF_FFFF;
            field_sh       <= '0;
            pay_sh         <= '0;
            stage_src_mac  <= '0;
            stage_src_ip   <= '0;
            stage_src_port <= '0;
            bus.data       <= '0;
            bus.src_mac    <= '0;
            bus.src_ip     <= '0;
            bus.src_port   <= '0;
            bus.valid      <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            rx_clk_s  <= {rx_clk_s[1:0], bus.rx_clk};
            rx_dv_s   <= {rx_dv_s[0], bus.rx_dv};
            rx_d_s0   <= bus.rx_d;
            rx_d_s1   <= rx_d_s0;
            bus.valid <= 1'b0;
            bus.error <= 1'b0;

            // A new frame may only start once rx_dv has been seen low.
            if (!dv_c)              armed <= 1'b1;
            else if (state != IDLE) armed <= 1'b0;

            if (state == PREAMBLE && nib_stb_c && nib_c == 4'hD) begin
                crc      <= 32'hFFFF_FFFF;
                byte_cnt <= '0;
                nib_hi   <= 1'b0;
            end

            if (in_frame_c && nib_stb_c) begin
                if (!nib_hi) nib_lo <= nib_c;
                nib_hi <= ~nib_hi;
            end

            if (byte_stb_c) begin
                crc      <= crc_byte(crc, rx_byte_c);
                field_sh <= hdr_cur_c[39:0];
                if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + CW'(1);
                if (state == HEADER) begin
                    case (byte_cnt)
                        11'd11:  stage_src_mac  <= hdr_cur_c;
                        11'd29:  stage_src_ip   <= hdr_cur_c[31:0];
                        11'd35:  stage_src_port <= hdr_cur_c[15:0];
                        default: ;
                    endcase
                end
                if (state == PAYLOAD) pay_sh <= PW'({pay_sh, rx_byte_c});
            end

            if ((state == HEADER || state == PAYLOAD) && !dv_c) bus.error <= 1'b1;

            if (state == CHECK) begin
                if (crc == CRC_RESIDUE && byte_cnt >= CW'(MIN_FRAME)) begin
                    bus.data     <= pay_sh;
                    bus.src_mac  <= stage_src_mac;
                    bus.src_ip   <= stage_src_ip;
                    bus.src_port <= stage_src_port;
                    bus.valid    <= 1'b1;
                end else begin
                    bus.error    <= 1'b1;
                end
            end
        end
    end
endmodule
